// File: rtl/seq_pkg.sv
// Shared types and defaults for the core sequencer.
// State encoding and the counter/limit defaults live here.
package seq_pkg;

  localparam int          CW_DEF   = 16;
  localparam int unsigned TMAX_DEF = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RESET_CORE,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/run_counter.sv
// Saturating run-cycle counter.
// Raises terminal at TMAX-1 and stops there.
module run_counter
  import seq_pkg::*;
#(
  parameter int          CW   = CW_DEF,
  parameter int unsigned TMAX = TMAX_DEF
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(TMAX - 1);

  assign terminal = (count == LAST);

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (enable && !terminal)
      count <= count + CW'(1);
  end

endmodule

// File: rtl/core_sequencer.sv
// Load / reset / run / done sequencer for a CPU core.
// Preloads data memory, holds core reset, times the run.
module core_sequencer
  import seq_pkg::*;
#(
  parameter int          CW   = CW_DEF,
  parameter int unsigned TMAX = TMAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  input  logic          core_done,
  output logic          core_reset,
  output logic          mem_wr_en,
  output logic [7:0]    mem_addr,
  output logic [7:0]    mem_dat,
  output logic          busy,
  output logic          finished,
  output logic [CW-1:0] cycle_cnt,
  output logic          timeout
);

  state_t state, state_n;
  logic   rc_q, rc_n;
  logic   to_n;
  logic   cnt_clear, cnt_en, terminal;

  run_counter #(
    .CW   (CW),
    .TMAX (TMAX)
  ) u_cnt (
    .clk      (clk),
    .clear    (reset || cnt_clear),
    .enable   (cnt_en),
    .count    (cycle_cnt),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rc_q    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      rc_q    <= rc_n;
      timeout <= to_n;
    end
  end

  always_comb begin
    state_n    = state;
    rc_n       = 1'b0;
    to_n       = timeout;
    core_reset = 1'b1;
    ld_ready   = 1'b0;
    busy       = 1'b0;
    finished   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_n = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (ld_valid && ld_last)
          state_n = S_RESET_CORE;
      end
      S_RESET_CORE: begin
        busy      = 1'b1;
        cnt_clear = 1'b1;
        to_n      = 1'b0;
        rc_n      = !rc_q;
        if (rc_q)
          state_n = S_RUN;
      end
      S_RUN: begin
        core_reset = 1'b0;
        busy       = 1'b1;
        cnt_en     = 1'b1;
        // cycle_cnt is still 0 in the first RUN cycle, masking a stale done
        if (core_done && (cycle_cnt != '0)) begin
          state_n = S_DONE;
          to_n    = 1'b0;
        end else if (terminal) begin
          state_n = S_DONE;
          to_n    = 1'b1;
        end
      end
      S_DONE: begin
        finished = 1'b1;
        if (start)
          state_n = S_LOAD;
      end
      default: state_n = S_IDLE;
    endcase
    if (reset)
      ld_ready = 1'b0;
  end

  assign mem_wr_en = ld_valid && ld_ready;
  assign mem_addr  = ld_addr;
  assign mem_dat   = ld_data;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: default and TMAX=8 instances in lockstep.
// A mode-level model is compared every cycle, plus literal pins.
module tb_core_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, ld_valid, ld_last, core_done;
  logic [7:0] ld_addr, ld_data;

  logic        ld_ready_o[2];
  logic        core_reset_o[2];
  logic        mem_wr_en_o[2];
  logic [7:0]  mem_addr_o[2];
  logic [7:0]  mem_dat_o[2];
  logic        busy_o[2];
  logic        finished_o[2];
  logic [15:0] cnt_o[2];
  logic        timeout_o[2];

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  core_sequencer u_dut0 (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready_o[0]),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .core_done(core_done), .core_reset(core_reset_o[0]),
    .mem_wr_en(mem_wr_en_o[0]), .mem_addr(mem_addr_o[0]),
    .mem_dat(mem_dat_o[0]), .busy(busy_o[0]),
    .finished(finished_o[0]), .cycle_cnt(cnt_o[0]),
    .timeout(timeout_o[0])
  );

  core_sequencer #(.CW(16), .TMAX(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready_o[1]),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .core_done(core_done), .core_reset(core_reset_o[1]),
    .mem_wr_en(mem_wr_en_o[1]), .mem_addr(mem_addr_o[1]),
    .mem_dat(mem_dat_o[1]), .busy(busy_o[1]),
    .finished(finished_o[1]), .cycle_cnt(cnt_o[1]),
    .timeout(timeout_o[1])
  );

  // model: 0 idle, 1 load, 2 core reset, 3 run, 4 done
  int m_mode[2];
  int m_runs[2];
  int m_rc[2];
  int m_to[2];
  int tmaxv[2] = '{65535, 8};

  task automatic chk(input string nm, input int idx,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[dut%0d] got=%0d want=%0d t=%0t",
               nm, idx, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mode[i] = 0;
        m_runs[i] = 0;
        m_to[i]   = 0;
      end else begin
        case (m_mode[i])
          0: if (start) m_mode[i] = 1;
          1: if (ld_valid && ld_last) begin
            m_mode[i] = 2;
            m_rc[i]   = 2;
          end
          2: begin
            m_runs[i] = 0;
            m_to[i]   = 0;
            m_rc[i]   = m_rc[i] - 1;
            if (m_rc[i] == 0) m_mode[i] = 3;
          end
          3: begin
            bit hit, dn;
            hit = (m_runs[i] == tmaxv[i] - 1);
            dn  = core_done && (m_runs[i] > 0);
            if (m_runs[i] < tmaxv[i] - 1) m_runs[i]++;
            if (dn) begin
              m_mode[i] = 4;
              m_to[i]   = 0;
            end else if (hit) begin
              m_mode[i] = 4;
              m_to[i]   = 1;
            end
          end
          4: if (start) m_mode[i] = 1;
          default: m_mode[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        int wr;
        wr = (m_mode[i] == 1) && ld_valid && !reset;
        chk("core_reset", i, int'(core_reset_o[i]),
            int'(m_mode[i] != 3));
        chk("ld_ready", i, int'(ld_ready_o[i]),
            int'(m_mode[i] == 1 && !reset));
        chk("busy", i, int'(busy_o[i]),
            int'(m_mode[i] >= 1 && m_mode[i] <= 3));
        chk("finished", i, int'(finished_o[i]),
            int'(m_mode[i] == 4));
        chk("cycle_cnt", i, int'(cnt_o[i]), m_runs[i]);
        chk("timeout", i, int'(timeout_o[i]), m_to[i]);
        chk("mem_wr_en", i, int'(mem_wr_en_o[i]), wr);
        if (wr != 0) begin
          chk("mem_addr", i, int'(mem_addr_o[i]), int'(ld_addr));
          chk("mem_dat", i, int'(mem_dat_o[i]), int'(ld_data));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_core_reset"}, i, int'(core_reset_o[i]), 1);
      chk({tag, "_ld_ready"}, i, int'(ld_ready_o[i]), 0);
      chk({tag, "_wr_en"}, i, int'(mem_wr_en_o[i]), 0);
      chk({tag, "_busy"}, i, int'(busy_o[i]), 0);
      chk({tag, "_finished"}, i, int'(finished_o[i]), 0);
      chk({tag, "_cnt"}, i, int'(cnt_o[i]), 0);
      chk({tag, "_timeout"}, i, int'(timeout_o[i]), 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    core_done = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    cyc();
    armed = 1'b1;
    cyc();
    #3 lit_reset_vals("rst");

    // loader byte offered while idle is dropped
    cyc();
    reset = 1'b0; ld_valid = 1'b1; ld_addr = 8'h55; ld_data = 8'h66;
    #3 chk("idle_wr", 0, int'(mem_wr_en_o[0]), 0);
    cyc();
    ld_valid = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      start = (s == 2);
      #3;
      chk("stall_ready", 0, int'(ld_ready_o[0]), 1);
      chk("stall_wr", 0, int'(mem_wr_en_o[0]), 0);
      cyc();
    end
    start = 1'b0;

    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1;
      ld_addr  = 8'h10 + 8'(k);
      ld_data  = 8'hA1 + 8'(k);
      ld_last  = (k == 2);
      #3;
      chk("ld_wr", k, int'(mem_wr_en_o[0]), 1);
      chk("ld_addr", k, int'(mem_addr_o[0]), 16 + k);
      chk("ld_dat", k, int'(mem_dat_o[0]), 161 + k);
      cyc();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int r = 0; r < 2; r++) begin
      #3 chk("rc_core_reset", r, int'(core_reset_o[0]), 1);
      cyc();
    end

    // done on the 10th RUN cycle; TMAX=8 copy times out first
    for (int n = 1; n <= 10; n++) begin
      core_done = (n == 10);
      if (n == 1) #3 chk("run1_core_reset", 0, int'(core_reset_o[0]), 0);
      cyc();
    end
    core_done = 1'b0;
    #3;
    chk("d10_finished", 0, int'(finished_o[0]), 1);
    chk("d10_cnt", 0, int'(cnt_o[0]), 10);
    chk("d10_timeout", 0, int'(timeout_o[0]), 0);
    chk("d10_core_reset", 0, int'(core_reset_o[0]), 1);
    chk("to8_finished", 1, int'(finished_o[1]), 1);
    chk("to8_cnt", 1, int'(cnt_o[1]), 7);
    chk("to8_timeout", 1, int'(timeout_o[1]), 1);

    // done exactly on the TMAX hit cycle
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0; ld_valid = 1'b1; ld_last = 1'b1;
    ld_addr = 8'h20; ld_data = 8'h5A;
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
    cyc();
    cyc();
    for (int n = 1; n <= 8; n++) begin
      core_done = (n == 8);
      cyc();
    end
    core_done = 1'b0;
    #3;
    chk("tie_cnt", 1, int'(cnt_o[1]), 7);
    chk("tie_timeout", 1, int'(timeout_o[1]), 0);
    chk("tie_finished", 1, int'(finished_o[1]), 1);
    chk("d8_cnt", 0, int'(cnt_o[0]), 8);

    // reset in the 4th RUN cycle
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0; ld_valid = 1'b1; ld_last = 1'b1;
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #3 lit_reset_vals("runrst");

    // transfer coinciding with reset must not write
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0; ld_valid = 1'b1; reset = 1'b1;
    ld_addr = 8'h77; ld_data = 8'h88;
    #3 chk("rst_xfer_wr", 0, int'(mem_wr_en_o[0]), 0);
    cyc();
    reset = 1'b0; ld_valid = 1'b0;
    #3 chk("rst_xfer_busy", 0, int'(busy_o[0]), 0);

    // done held high through core release
    cyc();
    core_done = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0; ld_valid = 1'b1; ld_last = 1'b1;
    ld_addr = 8'h30; ld_data = 8'hC3;
    #3 chk("rr_wr", 0, int'(mem_wr_en_o[0]), 1);
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
    cyc();
    cyc();
    start = 1'b1;
    #3 chk("rr_run1_finished", 0, int'(finished_o[0]), 0);
    cyc();
    start = 1'b0;
    cyc();
    core_done = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("hold_cnt", i, int'(cnt_o[i]), 2);
      chk("hold_finished", i, int'(finished_o[i]), 1);
      chk("hold_timeout", i, int'(timeout_o[i]), 0);
    end

    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
